// File: rtl/rv32i_core_top.sv
// Single-cycle RV32I integer core: PC, decoder, immediates, 32x32 register file,
// ALU and branch unit. Instructions arrive on `ins`; unsupported encodings retire as NOPs.
module rv32i_core_top #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     ins,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] alu_result,
  output logic            wb_en,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data
);

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_regs [32];

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rs1_addr;
  logic [4:0]      w_rs2_addr;
  logic [XLEN-1:0] w_rs1;
  logic [XLEN-1:0] w_rs2;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_pc_plus4;

  assign w_opcode   = ins[6:0];
  assign w_funct3   = ins[14:12];
  assign w_funct7   = ins[31:25];
  assign w_rs1_addr = ins[19:15];
  assign w_rs2_addr = ins[24:20];
  assign w_pc_plus4 = r_pc + XLEN'(4);

  assign w_imm_i = XLEN'($signed(ins[31:20]));
  assign w_imm_u = XLEN'($signed({ins[31:12], 12'b0}));
  assign w_imm_b = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
  assign w_imm_j = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));

  // x0 is hardwired to zero regardless of what the storage holds.
  assign w_rs1 = (w_rs1_addr == 5'd0) ? '0 : r_regs[w_rs1_addr];
  assign w_rs2 = (w_rs2_addr == 5'd0) ? '0 : r_regs[w_rs2_addr];

  alu_op_e         w_alu_op;
  logic [XLEN-1:0] w_alu_a;
  logic [XLEN-1:0] w_alu_b;
  logic [XLEN-1:0] w_alu_y;
  logic            w_we;
  logic            w_link;
  logic            w_br_taken;
  logic [XLEN-1:0] w_next_pc;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_alu_op = ALU_ADD;
    w_alu_a  = '0;
    w_alu_b  = '0;
    w_we     = 1'b0;
    w_link   = 1'b0;
    unique case (w_opcode)
      OPC_OP: begin
        w_alu_a = w_rs1;
        w_alu_b = w_rs2;
        w_we    = (w_funct7 == 7'b0000000);
        case (w_funct3)
          3'b000: begin
            w_alu_op = (w_funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
            w_we     = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
          end
          3'b001: w_alu_op = ALU_SLL;
          3'b010: w_alu_op = ALU_SLT;
          3'b011: w_alu_op = ALU_SLTU;
          3'b100: w_alu_op = ALU_XOR;
          3'b101: begin
            w_alu_op = (w_funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
            w_we     = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
          end
          3'b110: w_alu_op = ALU_OR;
          default: w_alu_op = ALU_AND;
        endcase
      end
      OPC_OP_IMM: begin
        w_alu_a = w_rs1;
        w_alu_b = w_imm_i;
        w_we    = 1'b1;
        case (w_funct3)
          3'b000: w_alu_op = ALU_ADD;
          3'b001: begin
            w_alu_op = ALU_SLL;
            w_we     = (w_funct7 == 7'b0000000);
          end
          3'b010: w_alu_op = ALU_SLT;
          3'b011: w_alu_op = ALU_SLTU;
          3'b100: w_alu_op = ALU_XOR;
          3'b101: begin
            w_alu_op = ins[30] ? ALU_SRA : ALU_SRL;
            w_we     = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
          end
          3'b110: w_alu_op = ALU_OR;
          default: w_alu_op = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        w_alu_b = w_imm_u;
        w_we    = 1'b1;
      end
      OPC_AUIPC: begin
        w_alu_a = r_pc;
        w_alu_b = w_imm_u;
        w_we    = 1'b1;
      end
      OPC_JAL: begin
        w_alu_a = r_pc;
        w_alu_b = w_imm_j;
        w_we    = 1'b1;
        w_link  = 1'b1;
      end
      OPC_JALR: begin
        w_alu_a = w_rs1;
        w_alu_b = w_imm_i;
        w_we    = (w_funct3 == 3'b000);
        w_link  = (w_funct3 == 3'b000);
      end
      OPC_BRANCH: begin
        w_alu_a = r_pc;
        w_alu_b = w_imm_b;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_alu_y = '0;
    unique case (w_alu_op)
      ALU_ADD:  w_alu_y = w_alu_a + w_alu_b;
      ALU_SUB:  w_alu_y = w_alu_a - w_alu_b;
      ALU_SLL:  w_alu_y = w_alu_a << w_alu_b[4:0];
      ALU_SLT:  w_alu_y = XLEN'($signed(w_alu_a) < $signed(w_alu_b));
      ALU_SLTU: w_alu_y = XLEN'(w_alu_a < w_alu_b);
      ALU_XOR:  w_alu_y = w_alu_a ^ w_alu_b;
      ALU_SRL:  w_alu_y = w_alu_a >> w_alu_b[4:0];
      ALU_SRA:  w_alu_y = $signed(w_alu_a) >>> w_alu_b[4:0];
      ALU_OR:   w_alu_y = w_alu_a | w_alu_b;
      default:  w_alu_y = w_alu_a & w_alu_b;
    endcase
  end

  always_comb begin
    w_br_taken = 1'b0;
    case (w_funct3)
      3'b000: w_br_taken = (w_rs1 == w_rs2);
      3'b001: w_br_taken = (w_rs1 != w_rs2);
      3'b100: w_br_taken = ($signed(w_rs1) <  $signed(w_rs2));
      3'b101: w_br_taken = ($signed(w_rs1) >= $signed(w_rs2));
      3'b110: w_br_taken = (w_rs1 <  w_rs2);
      3'b111: w_br_taken = (w_rs1 >= w_rs2);
      default: w_br_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (w_opcode == OPC_JAL)
      w_next_pc = w_alu_y;
    else if (w_opcode == OPC_JALR && w_funct3 == 3'b000)
      w_next_pc = {w_alu_y[XLEN-1:1], 1'b0};
    else if (w_opcode == OPC_BRANCH && w_br_taken)
      w_next_pc = w_alu_y;
  end

  assign pc_out     = r_pc;
  assign alu_result = w_alu_y;
  assign wb_en      = w_we & rst;
  assign wb_addr    = ins[11:7];
  assign wb_data    = w_link ? w_pc_plus4 : w_alu_y;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pc <= RESET_PC;
    else      r_pc <= w_next_pc;
  end

  // NOTE: the register file is reset on purpose (cleared on rst), which maps it to flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (wb_en && wb_addr != 5'd0) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

endmodule

// File: tb/tb_rv32i_core_top.sv
// Self-checking bench for rv32i_core_top: expected retire results are queued as
// each instruction is driven and compared when the core presents them.
module tb_rv32i_core_top;

  logic        clk;
  logic        rst;
  logic [31:0] ins;
  logic [31:0] pc_out;
  logic [31:0] alu_result;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } exp_t;

  exp_t exp_q[$];

  rv32i_core_top #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins),
    .pc_out     (pc_out),
    .alu_result (alu_result),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Drive one instruction, compare its queued expectation, then retire it on the next edge.
  task automatic step(input string tag, input logic [31:0] i, input logic [31:0] e_pc,
                      input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd);
    exp_t e;
    e.tag = tag; e.pc = e_pc; e.we = e_we; e.wa = e_wa; e.wd = e_wd;
    exp_q.push_back(e);
    ins = i;
    #1;
    e = exp_q.pop_front();
    check({e.tag, ".pc"}, pc_out, e.pc);
    check({e.tag, ".wb_en"}, 32'(wb_en), 32'(e.we));
    if (e.we) begin
      check({e.tag, ".wb_addr"}, 32'(wb_addr), 32'(e.wa));
      check({e.tag, ".wb_data"}, wb_data, e.wd);
    end
    @(posedge clk);
    #1;
  endtask

  // Read register n through the ALU with "add x0, xn, x0"; no clock edge is consumed.
  task automatic peek(input int n, input logic [31:0] exp);
    logic [4:0] r;
    r   = 5'(n);
    ins = {7'b0, 5'd0, r, 3'b000, 5'd0, 7'b0110011};
    #1;
    check($sformatf("x%0d", n), alu_result, exp);
  endtask

  initial begin
    rst = 1'b0;
    ins = 32'h0070_0093;

    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst.pc", pc_out, 32'h0);
      check("rst.wb_en", 32'(wb_en), 32'h0);
    end
    for (int r = 0; r < 32; r++) peek(r, 32'h0);

    @(negedge clk);
    rst = 1'b1;

    step("addi_x1",  32'h0070_0093, 32'h00, 1'b1, 5'd1, 32'd7);
    step("addi_x2",  32'h00C0_0113, 32'h04, 1'b1, 5'd2, 32'd12);
    step("add_x3",   32'h0020_81B3, 32'h08, 1'b1, 5'd3, 32'h13);
    check("pc_after_3", pc_out, 32'h0C);
    peek(3, 32'h13);
    step("addi_x0",  32'h0050_0013, 32'h0C, 1'b1, 5'd0, 32'd5);
    peek(0, 32'h0);
    step("addi_m1",  32'hFFF0_0093, 32'h10, 1'b1, 5'd1, 32'hFFFF_FFFF);
    step("slt",      32'h0000_A233, 32'h14, 1'b1, 5'd4, 32'd1);
    step("sltu",     32'h0000_B2B3, 32'h18, 1'b1, 5'd5, 32'd0);
    step("srai",     32'h4040_D313, 32'h1C, 1'b1, 5'd6, 32'hFFFF_FFFF);
    step("sub",      32'h4011_03B3, 32'h20, 1'b1, 5'd7, 32'd13);
    step("srl",      32'h0020_D433, 32'h24, 1'b1, 5'd8, 32'h000F_FFFF);
    step("jalr",     32'h0100_0067, 32'h28, 1'b1, 5'd0, 32'h2C);
    step("beq",      32'h0000_0463, 32'h10, 1'b0, 5'd0, 32'h0);
    step("jal",      32'hFF9F_F0EF, 32'h18, 1'b1, 5'd1, 32'h1C);
    peek(1, 32'h1C);
    step("bne_nt",   32'h0000_1463, 32'h10, 1'b0, 5'd0, 32'h0);
    step("blt_t",    32'h0003_4463, 32'h14, 1'b0, 5'd0, 32'h0);
    step("bgeu_t",   32'h0003_7463, 32'h1C, 1'b0, 5'd0, 32'h0);
    step("lw_nop",   32'h0000_2483, 32'h24, 1'b0, 5'd0, 32'h0);
    step("lui",      32'h1234_5537, 32'h28, 1'b1, 5'd10, 32'h1234_5000);
    step("auipc",    32'h0000_1597, 32'h2C, 1'b1, 5'd11, 32'h0000_102C);
    peek(4, 32'd1);
    peek(8, 32'h000F_FFFF);

    // Mid-cycle reset: state must clear before the next rising edge.
    ins = 32'h0000_1597;
    rst = 1'b0;
    #1;
    check("async.pc", pc_out, 32'h0);
    check("async.wb_en", 32'(wb_en), 32'h0);
    peek(3, 32'h0);
    peek(10, 32'h0);

    @(negedge clk);
    rst = 1'b1;
    step("post_rst", 32'h0070_0093, 32'h00, 1'b1, 5'd1, 32'd7);
    peek(1, 32'd7);
    check("post_rst.pc", pc_out, 32'h04);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
